// File: rtl/mips_pkg.sv
// Shared types and widths for the MEM stage: FSM state encoding and datapath constants.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } mem_state_e;

    // Word accesses only: the two byte-offset bits must be clear.
    function automatic logic is_word_aligned(input logic [1:0] byte_offset);
        return byte_offset == 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears every field so write-back sees a no-op.
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bubble,
    input  logic                  reg_write,
    input  logic                  mem_to_reg,
    input  logic [DATA_W-1:0]     read_data,
    input  logic [DATA_W-1:0]     alu_res,
    input  logic [REG_ADDR_W-1:0] reg_dest,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [DATA_W-1:0]     wb_read_data,
    output logic [DATA_W-1:0]     wb_alu_res,
    output logic [REG_ADDR_W-1:0] wb_reg_dest
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_res    <= '0;
            wb_reg_dest   <= '0;
        end else if (bubble) begin
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_res    <= '0;
            wb_reg_dest   <= '0;
        end else begin
            wb_reg_write  <= reg_write;
            wb_mem_to_reg <= mem_to_reg;
            wb_read_data  <= read_data;
            wb_alu_res    <= alu_res;
            wb_reg_dest   <= reg_dest;
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage controller: issues one data-memory access at a time over req/gnt/rvalid,
// stalls the front of the pipeline until it completes, then loads MEM/WB.
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [DATA_W-1:0]     ex_alu_res,
    input  logic [DATA_W-1:0]     ex_rt_data,
    input  logic [REG_ADDR_W-1:0] ex_reg_dest,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_W-1:0]     dmem_addr,
    output logic [DATA_W-1:0]     dmem_wdata,
    input  logic                  dmem_gnt,
    input  logic                  dmem_rvalid,
    input  logic [DATA_W-1:0]     dmem_rdata,
    output logic                  wb_reg_write,
    output logic                  wb_mem_to_reg,
    output logic [DATA_W-1:0]     wb_read_data,
    output logic [DATA_W-1:0]     wb_alu_res,
    output logic [REG_ADDR_W-1:0] wb_reg_dest,
    output logic                  misalign_err
);

    mem_state_e        state;
    mem_state_e        state_next;
    logic              mem_op;
    logic              aligned;
    logic              issue;
    logic              stall_int;
    logic              wb_bubble;
    logic [DATA_W-1:0] wb_read_sel;
    logic [DATA_W-1:0] load_buf;

    assign mem_op  = ex_valid & (ex_mem_read | ex_mem_write);
    assign aligned = is_word_aligned(ex_alu_res[1:0]);
    assign issue   = mem_op & aligned;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // dmem_we stays valid after the grant, so it tells a finished store from a pending load.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue)       state_next = REQ;
            REQ:     if (dmem_gnt)    state_next = dmem_we ? DONE : WAIT_R;
            WAIT_R:  if (dmem_rvalid) state_next = DONE;
            DONE:                     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_int   = 1'b0;
        wb_bubble   = 1'b1;
        wb_read_sel = '0;
        case (state)
            IDLE: begin
                stall_int = issue;
                wb_bubble = mem_op;
            end
            REQ, WAIT_R: begin
                stall_int = 1'b1;
            end
            DONE: begin
                wb_bubble   = 1'b0;
                wb_read_sel = dmem_we ? '0 : load_buf;
            end
            default: begin
                stall_int = 1'b0;
            end
        endcase
    end

    // Gated by rst_n so an asserted reset forces stall low even with a memory op waiting.
    assign stall = rst_n & stall_int;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (state == IDLE && issue) begin
            dmem_req   <= 1'b1;
            dmem_we    <= ex_mem_write;
            dmem_addr  <= ex_alu_res;
            dmem_wdata <= ex_mem_write ? ex_rt_data : '0;
        end else if (state == REQ && dmem_gnt) begin
            dmem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_buf     <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (state == IDLE) && mem_op && !aligned;
            if (state == WAIT_R && dmem_rvalid) begin
                load_buf <= dmem_rdata;
            end
        end
    end

    mem_wb_reg #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mem_wb_reg (
        .clk           (clk),
        .rst_n         (rst_n),
        .bubble        (wb_bubble),
        .reg_write     (ex_valid & ex_reg_write),
        .mem_to_reg    (ex_mem_to_reg),
        .read_data     (wb_read_sel),
        .alu_res       (ex_alu_res),
        .reg_dest      (ex_reg_dest),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .wb_read_data  (wb_read_data),
        .wb_alu_res    (wb_alu_res),
        .wb_reg_dest   (wb_reg_dest)
    );

endmodule
